// File: rtl/vga_scanout_gen.sv
// vga_scanout_gen: raster timing generator with double-buffered, pixel/line
// replicated framebuffer scan-out. Stage 0 is the hc/vc counter state; the
// framebuffer read is issued from stage 0. Video outputs appear two strobes later.
module vga_scanout_gen #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 40,
  parameter int   H_SYNC   = 128,
  parameter int   H_BP     = 88,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 4,
  parameter int   V_BP     = 23,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   SCALE    = 2,
  parameter int   COLOR_W  = 3,
  parameter int   ADDR_W   = 18
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pix_stb,
  input  logic               i_swap_req,
  output logic               o_swap_ack,
  output logic               o_front,
  output logic               o_rd_en,
  output logic [ADDR_W-1:0]  o_rd_addr,
  input  logic [COLOR_W-1:0] i_rd_data,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_de,
  output logic [COLOR_W-1:0] o_rgb,
  output logic               o_frame_start,
  output logic               o_vblank_start
);

  localparam int FB_W    = H_ACTIVE / SCALE;
  localparam int FB_H    = V_ACTIVE / SCALE;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int REP_W   = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(SCALE - 1);
  localparam logic [ADDR_W-1:0] FB_WORDS  = ADDR_W'(FB_W * FB_H);
  localparam logic [ADDR_W-1:0] FB_STRIDE = ADDR_W'(FB_W);

  if (SCALE < 1) begin : g_bad_scale
    $error("SCALE must be at least 1");
  end
  if ((H_ACTIVE % SCALE) != 0) begin : g_bad_h
    $error("H_ACTIVE must be a multiple of SCALE");
  end
  if ((V_ACTIVE % SCALE) != 0) begin : g_bad_v
    $error("V_ACTIVE must be a multiple of SCALE");
  end
  if ((longint'(2) * FB_W * FB_H) > (longint'(1) << ADDR_W)) begin : g_bad_addr
    $error("two framebuffer banks do not fit in ADDR_W");
  end

  logic [HC_W-1:0]   hc;
  logic [VC_W-1:0]   vc;
  logic [REP_W-1:0]  hrep;
  logic [REP_W-1:0]  vrep;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] line_start;
  logic [ADDR_W-1:0] next_line;
  logic [ADDR_W-1:0] next_base;
  logic              front;
  logic              pending;
  logic              active_p0;
  logic              hs_p0;
  logic              vs_p0;
  logic              line_end;
  logic              frame_end;
  logic              swap_now;
  logic              de_p1;
  logic              hs_p1;
  logic              vs_p1;
  logic              vld_p1;
  logic [COLOR_W-1:0] data_hold;

  // Stage 0: decode the counter position and the frame-boundary swap decision
  always_comb begin
    active_p0 = (int'(hc) < H_ACTIVE) && (int'(vc) < V_ACTIVE);
    hs_p0     = (int'(hc) >= H_ACTIVE + H_FP) && (int'(hc) < H_ACTIVE + H_FP + H_SYNC);
    vs_p0     = (int'(vc) >= V_ACTIVE + V_FP) && (int'(vc) < V_ACTIVE + V_FP + V_SYNC);
    line_end  = (int'(hc) == H_TOTAL - 1);
    frame_end = line_end && (int'(vc) == V_TOTAL - 1);
    swap_now  = i_pix_stb && frame_end && (pending || i_swap_req);
    next_line = line_start + FB_STRIDE;
    next_base = (front ^ swap_now) ? FB_WORDS : '0;
  end

  assign o_rd_en        = i_pix_stb && !i_rst && active_p0;
  assign o_rd_addr      = addr;
  assign o_front        = front;
  assign o_frame_start  = i_pix_stb && !i_rst && (hc == '0) && (vc == '0);
  assign o_vblank_start = i_pix_stb && !i_rst && (hc == '0) && (int'(vc) == V_ACTIVE);

  // Raster counters advance once per pixel strobe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hc <= '0;
      vc <= '0;
    end else if (i_pix_stb) begin
      if (line_end) begin
        hc <= '0;
        vc <= frame_end ? '0 : vc + VC_W'(1);
      end else begin
        hc <= hc + HC_W'(1);
      end
    end
  end

  // Incremental address generation: the word advances every SCALE active pixels,
  // and each framebuffer line is replayed SCALE times from line_start
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr       <= '0;
      line_start <= '0;
      hrep       <= '0;
      vrep       <= '0;
    end else if (i_pix_stb) begin
      if (frame_end) begin
        addr       <= next_base;
        line_start <= next_base;
        hrep       <= '0;
        vrep       <= '0;
      end else if (line_end) begin
        hrep <= '0;
        if (int'(vc) < V_ACTIVE) begin
          if (vrep == REP_LAST) begin
            vrep       <= '0;
            line_start <= next_line;
            addr       <= next_line;
          end else begin
            vrep <= vrep + REP_W'(1);
            addr <= line_start;
          end
        end
      end else if (active_p0 && (int'(hc) != H_ACTIVE - 1)) begin
        if (hrep == REP_LAST) begin
          hrep <= '0;
          addr <= addr + ADDR_W'(1);
        end else begin
          hrep <= hrep + REP_W'(1);
        end
      end
    end
  end

  // Bank swap: a request is remembered until the last strobe of the frame
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      front      <= 1'b0;
      pending    <= 1'b0;
      o_swap_ack <= 1'b0;
    end else begin
      o_swap_ack <= swap_now;
      if (swap_now) begin
        front   <= ~front;
        pending <= 1'b0;
      end else if (i_swap_req) begin
        pending <= 1'b1;
      end
    end
  end

  // Stage 1: timing flags follow the read; read data is held in case strobes are sparse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      de_p1  <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= o_rd_en;
      if (i_pix_stb) begin
        de_p1 <= active_p0;
        hs_p1 <= hs_p0;
        vs_p1 <= vs_p0;
      end
    end
  end

  // Capture read data the cycle it returns
  always_ff @(posedge i_clk) begin
    if (vld_p1) data_hold <= i_rd_data;
  end

  // Stage 2: registered video outputs, blanked to zero outside active video
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_de  <= 1'b0;
      o_rgb <= '0;
      o_hs  <= ~HS_POL;
      o_vs  <= ~VS_POL;
    end else if (i_pix_stb) begin
      o_de  <= de_p1;
      o_hs  <= hs_p1 ? HS_POL : ~HS_POL;
      o_vs  <= vs_p1 ? VS_POL : ~VS_POL;
      o_rgb <= de_p1 ? (vld_p1 ? i_rd_data : data_hold) : '0;
    end
  end

endmodule

// File: tb/tb_vga_scanout_gen.sv
// tb_vga_scanout_gen: scoreboard bench for vga_scanout_gen. Two reduced-size
// instances (SCALE=2 active-high syncs, SCALE=1 active-low syncs) are driven
// one at a time against a behavioural raster/address model.
module tb_vga_scanout_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       stb_a, swp_a, stb_b, swp_b;
  logic       ack_a, front_a, rd_en_a, hs_a, vs_a, de_a, fs_a, vbs_a;
  logic [7:0] rd_addr_a;
  logic [2:0] rd_data_a, rgb_a;
  logic       ack_b, front_b, rd_en_b, hs_b, vs_b, de_b, fs_b, vbs_b;
  logic [6:0] rd_addr_b;
  logic [2:0] rd_data_b, rgb_b;

  vga_scanout_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .SCALE(2), .COLOR_W(3), .ADDR_W(8)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb_a), .i_swap_req(swp_a),
    .o_swap_ack(ack_a), .o_front(front_a), .o_rd_en(rd_en_a), .o_rd_addr(rd_addr_a),
    .i_rd_data(rd_data_a), .o_hs(hs_a), .o_vs(vs_a), .o_de(de_a), .o_rgb(rgb_a),
    .o_frame_start(fs_a), .o_vblank_start(vbs_a)
  );

  vga_scanout_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .SCALE(1), .COLOR_W(3), .ADDR_W(7)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb_b), .i_swap_req(swp_b),
    .o_swap_ack(ack_b), .o_front(front_b), .o_rd_en(rd_en_b), .o_rd_addr(rd_addr_b),
    .i_rd_data(rd_data_b), .o_hs(hs_b), .o_vs(vs_b), .o_de(de_b), .o_rgb(rgb_b),
    .o_frame_start(fs_b), .o_vblank_start(vbs_b)
  );

  // Framebuffer models: one-cycle read latency, contents = low address bits
  always @(posedge clk) if (rd_en_a) rd_data_a <= rd_addr_a[2:0];
  always @(posedge clk) if (rd_en_b) rd_data_b <= rd_addr_b[2:0];

  bit          cur;
  logic        obs_ack, obs_front, obs_rd_en, obs_hs, obs_vs, obs_de, obs_fs, obs_vbs;
  logic [31:0] obs_addr;
  logic [2:0]  obs_rgb;

  assign obs_ack   = cur ? ack_b   : ack_a;
  assign obs_front = cur ? front_b : front_a;
  assign obs_rd_en = cur ? rd_en_b : rd_en_a;
  assign obs_addr  = cur ? {25'd0, rd_addr_b} : {24'd0, rd_addr_a};
  assign obs_hs    = cur ? hs_b    : hs_a;
  assign obs_vs    = cur ? vs_b    : vs_a;
  assign obs_de    = cur ? de_b    : de_a;
  assign obs_rgb   = cur ? rgb_b   : rgb_a;
  assign obs_fs    = cur ? fs_b    : fs_a;
  assign obs_vbs   = cur ? vbs_b   : vbs_a;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  int ha, hf, hsy, hb, va, vf, vsy, vb, sc, ht, vt, fbw, fbh;
  bit pol_h, pol_v;
  int hc_m, vc_m;
  bit front_m, pend_m;

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
  } exp_t;

  exp_t q[$];
  exp_t last_e;
  bit   have_last;
  int   de_cnt, hs_cnt, vs_cnt, ack_cnt;

  task automatic configure(input bit which);
    if (!which) begin
      ha = 16; hf = 2; hsy = 3; hb = 3; va = 8; vf = 1; vsy = 2; vb = 2;
      sc = 2; pol_h = 1'b1; pol_v = 1'b1;
    end else begin
      ha = 10; hf = 2; hsy = 3; hb = 2; va = 6; vf = 1; vsy = 2; vb = 1;
      sc = 1; pol_h = 1'b0; pol_v = 1'b0;
    end
    ht  = ha + hf + hsy + hb;
    vt  = va + vf + vsy + vb;
    fbw = ha / sc;
    fbh = va / sc;
    cur = which;
  endtask

  // One clock: drive at the falling edge, check combinational outputs, clock,
  // then check registered outputs at the next falling edge.
  task automatic cycle(input bit stb, input bit swp, input bit rst_v);
    exp_t e;
    int   addr_e;
    bit   act, bnd, swap_e;
    rst = rst_v;
    stb_a = cur ? 1'b0 : stb;
    swp_a = cur ? 1'b0 : swp;
    stb_b = cur ? stb : 1'b0;
    swp_b = cur ? swp : 1'b0;
    #1;
    act    = (hc_m < ha) && (vc_m < va);
    addr_e = (front_m ? fbw * fbh : 0) + (vc_m / sc) * fbw + hc_m / sc;
    check_eq("rd_en", obs_rd_en, stb && !rst_v && act);
    if (stb && !rst_v && act) check_eq("rd_addr", obs_addr, addr_e);
    check_eq("frame_start", obs_fs, stb && !rst_v && hc_m == 0 && vc_m == 0);
    check_eq("vblank_start", obs_vbs, stb && !rst_v && hc_m == 0 && vc_m == va);
    if (stb && !rst_v) begin
      e.de  = act;
      e.hs  = (hc_m >= ha + hf && hc_m < ha + hf + hsy) ? pol_h : !pol_h;
      e.vs  = (vc_m >= va + vf && vc_m < va + vf + vsy) ? pol_v : !pol_v;
      e.rgb = act ? 3'(addr_e) : 3'd0;
      q.push_back(e);
    end
    bnd    = (hc_m == ht - 1) && (vc_m == vt - 1);
    swap_e = stb && !rst_v && bnd && (pend_m || swp);
    @(posedge clk);
    if (rst_v) begin
      hc_m = 0; vc_m = 0; pend_m = 0; front_m = 0;
      q.delete();
      have_last = 0;
    end else begin
      if (swap_e) begin
        front_m = !front_m;
        pend_m  = 0;
      end else if (swp) begin
        pend_m = 1;
      end
      if (stb) begin
        if (hc_m == ht - 1) begin
          hc_m = 0;
          vc_m = (vc_m == vt - 1) ? 0 : vc_m + 1;
        end else begin
          hc_m++;
        end
      end
    end
    @(negedge clk);
    check_eq("swap_ack", obs_ack, swap_e);
    ack_cnt += int'(obs_ack);
    check_eq("front", obs_front, front_m);
    if (rst_v) begin
      check_eq("rst_de", obs_de, 0);
      check_eq("rst_rgb", obs_rgb, 0);
      check_eq("rst_hs", obs_hs, !pol_h);
      check_eq("rst_vs", obs_vs, !pol_v);
      check_eq("rst_addr", obs_addr, 0);
    end else if (stb && q.size() == 2) begin
      e = q.pop_front();
      check_eq("de", obs_de, e.de);
      check_eq("hs", obs_hs, e.hs);
      check_eq("vs", obs_vs, e.vs);
      check_eq("rgb", obs_rgb, e.rgb);
      last_e    = e;
      have_last = 1;
      de_cnt += int'(obs_de);
      hs_cnt += int'(obs_hs == pol_h);
      vs_cnt += int'(obs_vs == pol_v);
    end else if (!stb && have_last) begin
      check_eq("hold_de", obs_de, last_e.de);
      check_eq("hold_hs", obs_hs, last_e.hs);
      check_eq("hold_vs", obs_vs, last_e.vs);
      check_eq("hold_rgb", obs_rgb, last_e.rgb);
    end
  endtask

  initial begin
    int ack_before;
    int n, guard;
    bit s;
    rst = 1'b1;
    stb_a = 0; swp_a = 0; stb_b = 0; swp_b = 0;
    hc_m = 0; vc_m = 0; front_m = 0; pend_m = 0; have_last = 0;
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; ack_cnt = 0;
    configure(1'b0);

    repeat (3) cycle(1'b0, 1'b0, 1'b1);

    // Full-rate frame 0: per-frame sync/data-enable totals
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    repeat (312) cycle(1'b1, 1'b0, 1'b0);
    check_eq("frame0_de_count", de_cnt, 128);
    check_eq("frame0_hs_count", hs_cnt, 39);
    check_eq("frame0_vs_count", vs_cnt, 48);

    // Two requests in one frame give exactly one swap at the boundary
    ack_cnt = 0;
    for (int i = 0; i < 312; i++) cycle(1'b1, (i == 100) || (i == 250), 1'b0);
    check_eq("single_ack", ack_cnt, 1);
    check_eq("front_after_swap", front_a, 1);

    // Sparse strobes over a whole frame from the back bank
    n = 0; guard = 0;
    while (n < 312 && guard < 5000) begin
      s = ($urandom_range(0, 2) != 0);
      cycle(s, 1'b0, 1'b0);
      n += int'(s);
      guard++;
    end
    check_eq("sparse_frame_done", n, 312);

    // Request coincident with the boundary strobe
    for (int i = 0; i < 1000 && !(hc_m == ht - 1 && vc_m == vt - 1); i++) cycle(1'b1, 1'b0, 1'b0);
    check_eq("reach_boundary", (hc_m == ht - 1) && (vc_m == vt - 1), 1);
    ack_cnt = 0;
    cycle(1'b1, 1'b1, 1'b0);
    check_eq("boundary_swap_ack", ack_cnt, 1);
    check_eq("front_back_to_0", front_a, 0);

    // Mid-frame reset discards a pending swap and restarts the frame
    for (int i = 0; i < 400 && vc_m != 4; i++) cycle(1'b1, i == 5, 1'b0);
    check_eq("reach_mid_frame", vc_m, 4);
    ack_before = ack_cnt;
    cycle(1'b1, 1'b0, 1'b1);
    repeat (320) cycle(1'b1, 1'b0, 1'b0);
    check_eq("no_ack_after_rst", ack_cnt, ack_before);
    check_eq("front_after_rst", front_a, 0);

    // SCALE=1 instance with active-low syncs
    configure(1'b1);
    repeat (2) cycle(1'b0, 1'b0, 1'b1);
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    repeat (170) cycle(1'b1, 1'b0, 1'b0);
    check_eq("b_de_count", de_cnt, 60);
    check_eq("b_hs_low_count", hs_cnt, 30);
    check_eq("b_vs_low_count", vs_cnt, 34);
    repeat (170) cycle(1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
